sdram_wr_arb: RTL and testbench
===============================

// Module: sdram_wr_arb
// PURPOSE
//  Two-requester round-robin arbiter for the single SDRAM write-command port (wr_data/wr_addr/wr_valid/wr_ready).
//  Requester 0 is the USB-FIFO drain path; requester 1 is a second write source (pattern gen / DMA).
//  Grant is held for a burst of BURST_LEN accepted beats, or released early when the owner drops valid.
//  Sits in the sdram_clk domain between the write sources and the SDRAM controller write port.
// PARAMETERS
//  DW        16  data width of every write beat
//  AW        22  SDRAM word-address width
//  BURST_LEN 8   max accepted beats per grant (>=1); the counter is $clog2(BURST_LEN+1) bits wide
// PORTS
//  sdram_clk  in   1   single clock; all logic is on its rising edge
//  rst        in   1   synchronous reset, active-high
//  r0_data    in   DW  requester 0 write data
//  r0_addr    in   AW  requester 0 write address
//  r0_valid   in   1   requester 0 beat valid
//  r0_ready   out  1   requester 0 beat accepted (= wr_ready & grant[0])
//  r1_data    in   DW  requester 1 write data
//  r1_addr    in   AW  requester 1 write address
//  r1_valid   in   1   requester 1 beat valid
//  r1_ready   out  1   requester 1 beat accepted (= wr_ready & grant[1])
//  wr_data    out  DW  to SDRAM ctrl: data of the granted requester, 0 when idle
//  wr_addr    out  AW  to SDRAM ctrl: address of the granted requester, 0 when idle
//  wr_valid   out  1   to SDRAM ctrl: valid of the granted requester, 0 when idle
//  wr_ready   in   1   from SDRAM ctrl: beat accepted when wr_valid & wr_ready
//  grant      out  2   one-hot current owner; 2'b00 = idle
//  busy       out  1   high when grant != 0
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, grant=0, beat_cnt=0, last_owner=1 (so requester 0 wins first).
//   Outputs after reset: wr_valid=0, wr_data=0, wr_addr=0, r0_ready=0, r1_ready=0, busy=0.
//   Reset mid-burst drops the grant immediately; a beat not yet accepted is not issued.
//  States: IDLE, GNT0, GNT1. grant/busy are registered and decoded from state.
//   The output mux and the ready lines are combinational from state and the inputs.
//  Handshake: a beat transfers on a cycle with wr_valid & wr_ready. Requesters hold data/addr stable while valid & !ready.
//   wr_ready is never forwarded to a non-granted requester.
//  IDLE: if any rN_valid is high, go to GNTn. If both are high, pick the requester != last_owner.
//   There is a one-cycle arbitration bubble out of IDLE.
//  GNTn, per cycle:
//   - beat accepted and beat_cnt==BURST_LEN-1 -> release (burst complete).
//   - rn_valid==0 -> release (early end); the arbiter never releases while rn_valid=1 and the beat is unaccepted.
//   - beat accepted otherwise -> beat_cnt+1 and stay in GNTn.
//  Release: last_owner<=n and beat_cnt<=0.
//   Next state: GNT(other) if the other valid is high; else GNTn if rn_valid is still high; else IDLE.
//   Back-to-back grants have no bubble.
//  Starvation: with both requesters saturated, grants alternate exactly per BURST_LEN beats.
//  wr_ready may be low for any number of cycles. beat_cnt counts accepted beats only. No timeout.
//  BURST_LEN=1: every accepted beat causes a release.
// TESTING
//  T1 reset: hold rst 3 cycles with both valids high -> wr_valid=0, grant=00, busy=0 throughout.
//   First grant after release of rst is 01.
//  T2 single source: r0_valid=1 continuously, wr_ready=1, BURST_LEN=8.
//   -> 8 beats, release, re-grant to r0 with no bubble; r1_ready stays 0.
//  T3 contention: both valid, wr_ready=1 -> grant sequence 01 (8 beats), 10 (8 beats), 01 ...
//   wr_addr tracks the owner's address each beat.
//  T4 backpressure: wr_ready toggles 1,0,1,0 during a GNT0 burst -> exactly 8 accepted beats before release.
//   wr_data is stable while wr_ready=0.
//  T5 early end: r1 drops valid after 3 accepted beats while r0 is valid -> next cycle grant=01, beat_cnt=0.
//  T6 mid-burst reset: rst after 4 beats of GNT1 -> next cycle grant=00, wr_valid=0.
//   After rst falls with both valid, grant=01.

Source files
------------

// File: rtl/sdram_wr_arb.sv
// Two-requester round-robin arbiter for the SDRAM controller write-command port.
// A grant lasts BURST_LEN accepted beats, or ends early when the owner drops valid.
module sdram_wr_arb #(
    parameter int DW        = 16,
    parameter int AW        = 22,
    parameter int BURST_LEN = 8
) (
    input  logic          sdram_clk,
    input  logic          rst,
    input  logic [DW-1:0] r0_data,
    input  logic [AW-1:0] r0_addr,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [DW-1:0] r1_data,
    input  logic [AW-1:0] r1_addr,
    input  logic          r1_valid,
    output logic          r1_ready,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            last_owner_q, last_owner_d;

    logic            own_valid;
    logic            oth_valid;
    logic            cur_owner;
    logic            accepted;
    logic            burst_done;

    assign grant    = {state_q == GNT1, state_q == GNT0};
    assign busy     = (state_q == GNT0) || (state_q == GNT1);
    assign r0_ready = wr_ready & grant[0];
    assign r1_ready = wr_ready & grant[1];
    assign wr_valid = own_valid;
    assign accepted = own_valid & wr_ready;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        own_valid = 1'b0;
        oth_valid = 1'b0;
        cur_owner = 1'b0;
        wr_data   = '0;
        wr_addr   = '0;
        unique case (state_q)
            GNT0: begin
                own_valid = r0_valid;
                oth_valid = r1_valid;
                cur_owner = 1'b0;
                wr_data   = r0_data;
                wr_addr   = r0_addr;
            end
            GNT1: begin
                own_valid = r1_valid;
                oth_valid = r0_valid;
                cur_owner = 1'b1;
                wr_data   = r1_data;
                wr_addr   = r1_addr;
            end
            default: ;
        endcase
    end

    assign burst_done = accepted && (beat_cnt_q == CW'(BURST_LEN - 1));

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the port last wins.
                if (r0_valid && r1_valid) state_d = last_owner_q ? GNT0 : GNT1;
                else if (r0_valid)        state_d = GNT0;
                else if (r1_valid)        state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (burst_done || !own_valid) begin
                    last_owner_d = cur_owner;
                    beat_cnt_d   = '0;
                    if (oth_valid)      state_d = cur_owner ? GNT0 : GNT1;
                    else if (own_valid) state_d = state_q;
                    else                state_d = IDLE;
                end else if (accepted) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_sdram_wr_arb.sv
// Bench for sdram_wr_arb: a BURST_LEN=8 and a BURST_LEN=1 instance share stimulus and are
// compared every cycle against an owner/beat-count model, plus directed literal checks.
module tb_sdram_wr_arb;

    localparam int DW = 16;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] r_data  [2];
    logic [AW-1:0] r_addr  [2];
    logic          r_valid [2];
    logic          wr_ready;

    logic [DW-1:0] o_data  [2];
    logic [AW-1:0] o_addr  [2];
    logic          o_valid [2];
    logic          o_r0rdy [2];
    logic          o_r1rdy [2];
    logic [1:0]    o_grant [2];
    logic          o_busy  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner -1 = idle, else requester index; beats = accepted beats in this grant.
    int  m_owner [2];
    int  m_beats [2];
    int  m_last  [2];
    bit  m_known = 1'b0;
    bit  m_acc   [2];

    always #5 clk = ~clk;

    sdram_wr_arb #(.DW(DW), .AW(AW), .BURST_LEN(8)) u_dut8 (
        .sdram_clk(clk), .rst(rst),
        .r0_data(r_data[0]), .r0_addr(r_addr[0]), .r0_valid(r_valid[0]), .r0_ready(o_r0rdy[0]),
        .r1_data(r_data[1]), .r1_addr(r_addr[1]), .r1_valid(r_valid[1]), .r1_ready(o_r1rdy[0]),
        .wr_data(o_data[0]), .wr_addr(o_addr[0]), .wr_valid(o_valid[0]), .wr_ready(wr_ready),
        .grant(o_grant[0]), .busy(o_busy[0])
    );

    sdram_wr_arb #(.DW(DW), .AW(AW), .BURST_LEN(1)) u_dut1 (
        .sdram_clk(clk), .rst(rst),
        .r0_data(r_data[0]), .r0_addr(r_addr[0]), .r0_valid(r_valid[0]), .r0_ready(o_r0rdy[1]),
        .r1_data(r_data[1]), .r1_addr(r_addr[1]), .r1_valid(r_valid[1]), .r1_ready(o_r1rdy[1]),
        .wr_data(o_data[1]), .wr_addr(o_addr[1]), .wr_valid(o_valid[1]), .wr_ready(wr_ready),
        .grant(o_grant[1]), .busy(o_busy[1])
    );

    function automatic int burst_len(input int inst);
        return (inst == 0) ? 8 : 1;
    endfunction

    task automatic check(input int inst, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h at %0t", inst, name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] e_grant, e_valid, e_data, e_addr;
        if (!m_known) return;
        for (int i = 0; i < 2; i++) begin
            e_grant = 0; e_valid = 0; e_data = 0; e_addr = 0;
            if (m_owner[i] >= 0) begin
                e_grant = 32'(1) << m_owner[i];
                e_valid = 32'(r_valid[m_owner[i]]);
                e_data  = 32'(r_data[m_owner[i]]);
                e_addr  = 32'(r_addr[m_owner[i]]);
            end
            check(i, "grant",    32'(o_grant[i]), e_grant);
            check(i, "busy",     32'(o_busy[i]),  32'(m_owner[i] >= 0));
            check(i, "wr_valid", 32'(o_valid[i]), e_valid);
            check(i, "wr_data",  32'(o_data[i]),  e_data);
            check(i, "wr_addr",  32'(o_addr[i]),  e_addr);
            check(i, "r0_ready", 32'(o_r0rdy[i]), 32'(wr_ready && m_owner[i] == 0));
            check(i, "r1_ready", 32'(o_r1rdy[i]), 32'(wr_ready && m_owner[i] == 1));
        end
    endtask

    // Applies one clock edge to the model using the inputs the DUT just sampled.
    task automatic model_step();
        int  n;
        bit  acc;
        m_acc[0] = 1'b0;
        m_acc[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_owner[i] = -1;
                m_beats[i] = 0;
                m_last[i]  = 1;
            end else if (m_owner[i] < 0) begin
                if (r_valid[0] && r_valid[1]) m_owner[i] = 1 - m_last[i];
                else if (r_valid[0])          m_owner[i] = 0;
                else if (r_valid[1])          m_owner[i] = 1;
            end else begin
                n   = m_owner[i];
                acc = r_valid[n] && wr_ready;
                if (i == 0) m_acc[n] = acc;
                if (acc) m_beats[i]++;
                if ((acc && m_beats[i] == burst_len(i)) || !r_valid[n]) begin
                    m_last[i]  = n;
                    m_beats[i] = 0;
                    if (r_valid[1-n])  m_owner[i] = 1 - n;
                    else if (r_valid[n]) m_owner[i] = n;
                    else               m_owner[i] = -1;
                end
            end
        end
        if (rst) m_known = 1'b1;
    endtask

    // Called just after a falling edge; new data only once the previous beat was taken.
    task automatic drive(input bit v0, input bit v1, input bit rdy, input bit r);
        bit v [2];
        v[0] = v0;
        v[1] = v1;
        for (int n = 0; n < 2; n++) begin
            if (m_acc[n] || !r_valid[n]) begin
                r_data[n] = DW'($urandom);
                r_addr[n] = AW'($urandom);
            end
            r_valid[n] = v[n];
        end
        wr_ready = rdy;
        rst      = r;
    endtask

    task automatic tick();
        #2;
        compare_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] held;
        bit            have_held;
        int            acc_cnt;
        bit            seen_g1;
        bit            v0, v1;

        rst = 1'b1; wr_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            r_valid[n] = 1'b0; r_data[n] = '0; r_addr[n] = '0;
            m_acc[n] = 1'b0; m_owner[n] = -1; m_beats[n] = 0; m_last[n] = 1;
        end
        @(negedge clk);

        // Reset held with both requesters asking; port must stay idle.
        drive(1, 1, 1, 1); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1); #1;
            check(0, "t1_grant", 32'(o_grant[0]), 32'h0);
            check(0, "t1_wr_valid", 32'(o_valid[0]), 32'h0);
            check(0, "t1_busy", 32'(o_busy[0]), 32'h0);
            tick();
        end
        drive(1, 1, 1, 0); tick();

        // Contention: alternating 8-beat grants starting with requester 0.
        drive(1, 1, 1, 0);
        for (int k = 0; k < 32; k++) begin
            #1;
            check(0, "t3_grant", 32'(o_grant[0]), ((k / 8) % 2 == 0) ? 32'h1 : 32'h2);
            check(0, "t3_wr_addr", 32'(o_addr[0]), 32'(r_addr[(k / 8) % 2]));
            tick();
            drive(1, 1, 1, 0);
        end

        // Single source: requester 0 re-granted with no idle bubble.
        drive(0, 0, 1, 1); tick();
        drive(1, 0, 1, 0); tick();
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 1, 0); #1;
            check(0, "t2_grant", 32'(o_grant[0]), 32'h1);
            check(0, "t2_r1_ready", 32'(o_r1rdy[0]), 32'h0);
            tick();
        end

        // Backpressure: ready toggles during a GNT0 burst.
        drive(1, 0, 1, 1); tick();
        drive(1, 0, 1, 0); tick();
        acc_cnt = 0; seen_g1 = 1'b0; have_held = 1'b0;
        for (int k = 0; k < 40 && !seen_g1; k++) begin
            drive(1, 1, (k % 2) == 0, 0); #1;
            if (o_grant[0] == 2'b10) seen_g1 = 1'b1;
            if (o_grant[0] == 2'b01) begin
                if (have_held) check(0, "t4_data_stable", 32'(o_data[0]), 32'(held));
                if (o_valid[0] && wr_ready) acc_cnt++;
                have_held = !wr_ready;
                held      = o_data[0];
            end
            tick();
        end
        check(0, "t4_switched", 32'(seen_g1), 32'h1);
        check(0, "t4_beats", 32'(acc_cnt), 32'd8);

        // Early end: requester 1 drops valid after 3 beats.
        drive(0, 1, 1, 1); tick();
        drive(0, 1, 1, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 0); #1;
            check(0, "t5_grant_r1", 32'(o_grant[0]), 32'h2);
            tick();
        end
        drive(1, 0, 1, 0); tick();
        for (int k = 0; k < 9; k++) begin
            drive(1, 1, 1, 0); #1;
            check(0, "t5_grant_after", 32'(o_grant[0]), (k < 8) ? 32'h1 : 32'h2);
            tick();
        end

        // Reset in the middle of a GNT1 burst.
        drive(0, 1, 1, 1); tick();
        drive(0, 1, 1, 0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 0); tick();
        end
        drive(1, 1, 1, 1); tick();
        drive(1, 1, 1, 0); #1;
        check(0, "t6_grant", 32'(o_grant[0]), 32'h0);
        check(0, "t6_wr_valid", 32'(o_valid[0]), 32'h0);
        tick();
        drive(1, 1, 1, 0); #1;
        check(0, "t6_regrant", 32'(o_grant[0]), 32'h1);
        tick();

        // Random traffic; unaccepted beats keep their data, valid rarely drops.
        for (int k = 0; k < 3000; k++) begin
            v0 = (r_valid[0] && !m_acc[0] && !rst) ? ($urandom_range(0, 15) != 0)
                                                   : ($urandom_range(0, 3) != 0);
            v1 = (r_valid[1] && !m_acc[1] && !rst) ? ($urandom_range(0, 15) != 0)
                                                   : ($urandom_range(0, 3) != 0);
            drive(v0, v1, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
